// File: rtl/spike_window_monitor_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spike_window_monitor_if                                                |
// | Spike input/enable and windowed statistics outputs of the monitor.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
interface spike_window_monitor_if;
  logic       spike;
  logic       en;
  logic [7:0] count;
  logic [7:0] isi;
  logic       valid;
  logic       burst;

  // master drives the neuron side; slave is the monitor itself
  modport master (output spike, en, input count, isi, valid, burst);
  modport slave  (input spike, en, output count, isi, valid, burst);
endinterface
`default_nettype wire

// File: rtl/spike_window_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | spike_window_monitor                                                   |
// | Counts rising spike edges per WINDOW enabled cycles and tracks the     |
// | last inter-spike interval; all statistics saturate at 255.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module spike_window_monitor #(
  parameter int WINDOW   = 16,
  parameter int BURST_TH = 4
) (
  input  wire                    clk,
  input  wire                    rst_n,
  spike_window_monitor_if.slave  bus
);

  localparam int               c_WIN_W    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WINDOW - 1);
  localparam logic [7:0]       c_BURST_TH = 8'(BURST_TH);

  logic               r_spike_d;
  logic [c_WIN_W-1:0] r_win_cnt;
  logic [7:0]         r_acc;
  logic [7:0]         r_isi_cnt;
  logic               r_seen;
  logic [7:0]         r_count;
  logic [7:0]         r_isi;
  logic               r_valid;
  logic               r_burst;

  logic               w_edge;
  logic               w_wrap;
  logic [7:0]         w_acc_next;
  logic [7:0]         w_isi_inc;

  // Edges are only counted in enabled cycles; a held level counts once.
  assign w_edge     = bus.spike & ~r_spike_d & bus.en;
  assign w_wrap     = bus.en & (r_win_cnt == c_WIN_LAST);
  assign w_acc_next = (r_acc == 8'hFF) ? 8'hFF : r_acc + {7'd0, w_edge};
  assign w_isi_inc  = (r_isi_cnt == 8'hFF) ? 8'hFF : r_isi_cnt + 8'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_spike_d <= 1'b0;
      r_win_cnt <= '0;
      r_acc     <= 8'd0;
      r_isi_cnt <= 8'd0;
      r_seen    <= 1'b0;
      r_count   <= 8'd0;
      r_isi     <= 8'd0;
      r_valid   <= 1'b0;
      r_burst   <= 1'b0;
    end else begin
      r_spike_d <= bus.spike;
      r_valid   <= 1'b0;
      if (bus.en) begin
        // The closing window absorbs an edge landing on its last cycle.
        if (w_wrap) begin
          r_count   <= w_acc_next;
          r_burst   <= (w_acc_next >= c_BURST_TH);
          r_acc     <= 8'd0;
          r_win_cnt <= '0;
          r_valid   <= 1'b1;
        end else begin
          r_acc     <= w_acc_next;
          r_win_cnt <= r_win_cnt + c_WIN_W'(1);
        end

        if (w_edge) begin
          r_isi_cnt <= 8'd1;
          r_seen    <= 1'b1;
          if (r_seen) begin
            r_isi <= r_isi_cnt;
          end
        end else begin
          r_isi_cnt <= w_isi_inc;
        end
      end
    end
  end

  assign bus.count = r_count;
  assign bus.isi   = r_isi;
  assign bus.valid = r_valid;
  assign bus.burst = r_burst;

endmodule
`default_nettype wire

// File: tb/tb_spike_window_monitor.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_spike_window_monitor                                                |
// | Scoreboard bench: window results queued at the wrap cycle, popped on   |
// | each valid pulse; ISI and reset behaviour checked inline.              |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_spike_window_monitor;

  localparam int c_WINDOW   = 16;
  localparam int c_BURST_TH = 4;

  typedef struct packed {
    logic [7:0] count;
    logic       burst;
  } exp_t;

  logic clk;
  logic rst_n;
  spike_window_monitor_if bus ();

  int   n_cmp;
  int   n_err;
  exp_t q[$];

  spike_window_monitor #(
    .WINDOW   (c_WINDOW),
    .BURST_TH (c_BURST_TH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every valid pulse must match the oldest queued window result.
  always @(negedge clk) begin
    if (bus.valid === 1'b1) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: valid=1 with no window pending at %0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        if (bus.count !== e.count) begin
          n_err++;
          $display("FAIL window_count: got %0d expected %0d at %0t", bus.count, e.count, $time);
        end
        n_cmp++;
        if (bus.burst !== e.burst) begin
          n_err++;
          $display("FAIL window_burst: got %0b expected %0b at %0t", bus.burst, e.burst, $time);
        end
      end
    end
  end

  // Apply one clock cycle of stimulus; returns 1 time unit after the edge.
  task automatic cyc(input logic sp, input logic en);
    bus.spike = sp;
    bus.en    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int cnt);
    exp_t e;
    e.count = (cnt > 255) ? 8'd255 : 8'(cnt);
    e.burst = (cnt >= c_BURST_TH);
    q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Let any pending valid pulse arrive, then require the queue to be empty.
  task automatic drain(input string name);
    bus.spike = 1'b0;
    bus.en    = 1'b0;
    for (int i = 0; i < 3 && q.size() != 0; i++) @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: %0d window results never produced, expected 0", name, q.size());
      q.delete();
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    bus.spike = 1'b1;
    bus.en    = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.count !== 8'd0) begin n_err++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
    n_cmp++;
    if (bus.isi !== 8'd0) begin n_err++; $display("FAIL reset_isi: got %0d expected 0", bus.isi); end
    n_cmp++;
    if (bus.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", bus.valid); end
    n_cmp++;
    if (bus.burst !== 1'b0) begin n_err++; $display("FAIL reset_burst: got %0b expected 0", bus.burst); end
    cyc(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  task automatic test_idle_window();
    do_reset();
    for (int i = 0; i < c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(0);
      cyc(1'b0, 1'b1);
    end
    drain("idle");
    n_cmp++;
    if (bus.isi !== 8'd0) begin n_err++; $display("FAIL idle_isi: got %0d expected 0", bus.isi); end
  endtask

  task automatic test_count_burst();
    logic sp;
    do_reset();
    for (int i = 0; i < c_WINDOW; i++) begin
      sp = (i == 1 || i == 4 || i == 8);
      if (i == c_WINDOW - 1) push_exp(3);
      cyc(sp, 1'b1);
    end
    for (int i = 0; i < c_WINDOW; i++) begin
      sp = (i == 0 || i == 2 || i == 4 || i == 6 || i == 8);
      if (i == c_WINDOW - 1) push_exp(5);
      cyc(sp, 1'b1);
      if (i == 5) begin
        n_cmp++;
        if (bus.count !== 8'd3 || bus.burst !== 1'b0) begin
          n_err++;
          $display("FAIL hold_between_wraps: count=%0d burst=%0b expected 3/0", bus.count, bus.burst);
        end
      end
    end
    drain("count_burst");
  endtask

  task automatic test_held_spike();
    do_reset();
    for (int i = 0; i < c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(1);
      cyc((i >= 2 && i < 12), 1'b1);
    end
    drain("held");
  endtask

  task automatic test_isi();
    logic sp;
    int   acc;
    acc = 0;
    do_reset();
    for (int i = 0; i < 20 * c_WINDOW; i++) begin
      sp  = (i == 2 || i == 7 || i == 307);
      acc = acc + int'(sp);
      if (i % c_WINDOW == c_WINDOW - 1) begin
        push_exp(acc);
        acc = 0;
      end
      cyc(sp, 1'b1);
      if (i == 2) begin
        n_cmp++;
        if (bus.isi !== 8'd0) begin n_err++; $display("FAIL isi_first_edge: got %0d expected 0", bus.isi); end
      end
      if (i == 7) begin
        n_cmp++;
        if (bus.isi !== 8'd5) begin n_err++; $display("FAIL isi_second_edge: got %0d expected 5", bus.isi); end
      end
      if (i == 307) begin
        n_cmp++;
        if (bus.isi !== 8'd255) begin n_err++; $display("FAIL isi_saturate: got %0d expected 255", bus.isi); end
      end
    end
    drain("isi");
  endtask

  task automatic test_wrap_edge();
    do_reset();
    for (int i = 0; i < 2 * c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(1);
      if (i == 2 * c_WINDOW - 1) push_exp(0);
      cyc((i == c_WINDOW - 1), 1'b1);
    end
    drain("wrap_edge");
  endtask

  task automatic test_en_gap_and_reset();
    do_reset();
    for (int i = 0; i < c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(2);
      cyc((i == 3 || i == 9), 1'b1);
    end
    for (int i = 0; i < 8; i++) cyc((i == 3), 1'b1);
    // Spikes while disabled must be lost and the window must freeze.
    for (int i = 0; i < 20; i++) begin
      cyc((i % 2 == 0) && (i < 19), 1'b0);
      n_cmp++;
      if (bus.count !== 8'd2 || bus.valid !== 1'b0) begin
        n_err++;
        $display("FAIL en_gap_freeze: count=%0d valid=%0b expected 2/0", bus.count, bus.valid);
      end
    end
    for (int i = 8; i < c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(1);
      cyc(1'b0, 1'b1);
    end
    drain("en_gap");

    for (int i = 0; i < 8; i++) cyc((i == 2 || i == 5), 1'b1);
    rst_n = 1'b0;
    cyc(1'b1, 1'b1);
    n_cmp++;
    if (bus.count !== 8'd0 || bus.isi !== 8'd0 || bus.valid !== 1'b0 || bus.burst !== 1'b0) begin
      n_err++;
      $display("FAIL midwindow_reset: count=%0d isi=%0d valid=%0b burst=%0b expected all 0",
               bus.count, bus.isi, bus.valid, bus.burst);
    end
    rst_n = 1'b1;
    for (int i = 0; i < c_WINDOW; i++) begin
      if (i == c_WINDOW - 1) push_exp(0);
      cyc(1'b0, 1'b1);
    end
    drain("post_reset");
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    bus.spike = 1'b0;
    bus.en    = 1'b0;
    test_reset();
    test_idle_window();
    test_count_burst();
    test_held_spike();
    test_isi();
    test_wrap_edge();
    test_en_gap_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/spike_window_monitor.md
SPIKE_WINDOW_MONITOR -- requirements
Module: spike_window_monitor

Interface
REQ-001 Parameter WINDOW, default 16, observation window length in enabled cycles (2..65535).
REQ-002 Parameter BURST_TH, default 4, spike count at or above which a window is flagged as a burst (1..255).
REQ-003 Port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, synchronous and active-low.
REQ-005 Port spike  input  1  spike level from the upstream integrate-and-fire neuron; may be a 1-cycle pulse or held high.
REQ-006 Port en  input  1  count enable; low freezes all counters.
REQ-007 Port count  output  8  spike count of the last completed window, saturating.
REQ-008 Port isi  output  8  last inter-spike interval in enabled cycles, saturating.
REQ-009 Port valid  output  1  one-cycle pulse; count and burst updated this cycle.
REQ-010 Port burst  output  1  high when the last completed window count >= BURST_TH.

Function
REQ-011 Edge detection SHALL use registered spike_d, updated every cycle regardless of en; edge = spike & ~spike_d; a held-high spike SHALL count once.
REQ-012 An edge SHALL be counted only in a cycle with en=1; edges in en=0 cycles are lost.
REQ-013 Window counter win_cnt SHALL advance 0..WINDOW-1 on each en=1 cycle and wrap to 0; it holds when en=0.
REQ-014 Accumulator acc (8 bits) SHALL increment on each counted edge, saturating at 255.
REQ-015 In an en=1 cycle with win_cnt==WINDOW-1: count <= sat255(acc+edge), burst <= (that value >= BURST_TH), acc <= 0, win_cnt <= 0, valid <= 1.
REQ-016 An edge in the wrap cycle SHALL be counted in the closing window, never in the next.
REQ-017 valid SHALL be 1 for exactly one cycle after each wrap and 0 otherwise, including all en=0 cycles.
REQ-018 count and burst SHALL hold their values between wraps.
REQ-019 ISI counter isi_cnt (8 bits) on en=1: if counted edge, isi_cnt <= 1; else isi_cnt <= sat255(isi_cnt+1).
REQ-020 On a counted edge with flag seen=1: isi <= isi_cnt; on any counted edge: seen <= 1.
REQ-021 The first counted edge after reset SHALL set seen without updating isi.
REQ-022 Edges at enabled cycles t and t+k (no en gaps) SHALL produce isi = min(k,255).
REQ-023 Outputs SHALL be registered; count/burst/valid change one cycle after the wrap cycle; isi changes one cycle after the edge cycle.

Reset
REQ-024 rst_n=0 at a clock edge SHALL clear spike_d, win_cnt, acc, isi_cnt, seen, count, isi, valid and burst to 0.
REQ-025 Reset SHALL take priority over en and spike; a reset mid-window SHALL discard the partial window and produce no valid pulse.
REQ-026 The first window after reset release SHALL span exactly WINDOW enabled cycles.

Verification (WINDOW=16, BURST_TH=4)
REQ-027 Reset, en=1, no spikes for 16 cycles -> one valid pulse with count=0, burst=0, isi=0.
REQ-028 Three 1-cycle spikes in window 1 -> count=3, burst=0; five spikes in window 2 -> count=5, burst=1.
REQ-029 Spike held high for 10 cycles -> count=1.
REQ-030 Pulses at enabled cycles 2, 7, 7+300 -> isi=5 after second edge; isi=255 after third; first edge leaves isi=0.
REQ-031 Spike on the wrap cycle (win_cnt=15) -> counted in the closing window; next window's count excludes it.
REQ-032 en=0 for 20 cycles mid-window with spikes applied -> no valid pulse, no count change; window resumes at frozen win_cnt. rst_n=0 at win_cnt=8 -> all outputs 0, next valid after 16 enabled cycles.
